// File: rtl/fpg8_ctrl_pkg.sv
// Shared encodings for the FPG8 hardwired control unit: opcodes, ALU functions,
// GPR select codes, sequencer states and the strobe bundle.
package fpg8_ctrl_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_AND   = 4'd5;
    localparam logic [3:0] OP_OR    = 4'd6;
    localparam logic [3:0] OP_MOV   = 4'd7;
    localparam logic [3:0] OP_HALT  = 4'd15;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_INC  = 3'd4;
    localparam logic [2:0] ALU_PASS = 3'd5;
    localparam logic [2:0] ALU_NOT  = 3'd6;

    localparam logic [2:0] SEL_RD1 = 3'd0;
    localparam logic [2:0] SEL_RD2 = 3'd1;
    localparam logic [2:0] SEL_RS1 = 3'd2;
    localparam logic [2:0] SEL_RS2 = 3'd3;
    localparam logic [2:0] SEL_PC  = 3'd4;

    typedef enum logic [3:0] {
        ST_FETCH0 = 4'd0,
        ST_FETCH1 = 4'd1,
        ST_FETCH2 = 4'd2,
        ST_FETCH3 = 4'd3,
        ST_DECODE = 4'd4,
        ST_EXEC0  = 4'd5,
        ST_EXEC1  = 4'd6,
        ST_EXEC2  = 4'd7,
        ST_EXEC3  = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic [2:0] alu_control;
        logic       gpr_in;
        logic       gpr_out;
        logic [2:0] gpr_select;
        logic       ir_in;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ram_rd;
        logic       ram_wr;
        logic       y_in;
        logic       z_in;
        logic       z_out;
        logic       halted;
    } strobes_t;

    localparam int STROBES_W = $bits(strobes_t);

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_OR);
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd14);
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

    // Final execute step of each instruction; the sequencer returns to FETCH0 after it.
    function automatic state_t last_exec(input logic [3:0] op);
        case (op)
            OP_LOAD: return ST_EXEC3;
            OP_MOV:  return ST_EXEC1;
            default: return ST_EXEC2;
        endcase
    endfunction

endpackage

// File: rtl/fpg8_ctrl_decode.sv
// Pure combinational strobe decoder: (state, opcode) -> raw datapath strobes,
// before any run/reset gating.
module fpg8_ctrl_decode
    import fpg8_ctrl_pkg::*;
#(
    parameter logic [2:0] PC_SEL = SEL_PC
) (
    input  logic [3:0]           state,
    input  logic [3:0]           opcode,
    output logic [STROBES_W-1:0] strobes
);

    strobes_t s;

    always_comb begin
        s = '0;
        case (state)
            ST_FETCH0: begin
                s.gpr_out     = 1'b1;
                s.gpr_select  = PC_SEL;
                s.mar_in      = 1'b1;
                s.alu_control = ALU_INC;
                s.z_in        = 1'b1;
            end
            ST_FETCH1: s.ram_rd = 1'b1;
            ST_FETCH2: begin
                s.z_out      = 1'b1;
                s.gpr_in     = 1'b1;
                s.gpr_select = PC_SEL;
            end
            ST_FETCH3: begin
                s.mdr_out = 1'b1;
                s.ir_in   = 1'b1;
            end
            ST_EXEC0: begin
                s.gpr_out = 1'b1;
                if (is_alu_op(opcode)) begin
                    s.gpr_select = SEL_RD1;
                    s.y_in       = 1'b1;
                end else if (opcode == OP_MOV) begin
                    s.gpr_select  = SEL_RS1;
                    s.alu_control = ALU_PASS;
                    s.z_in        = 1'b1;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    s.gpr_select = SEL_RS1;
                    s.mar_in     = 1'b1;
                end else begin
                    s.gpr_out = 1'b0;
                end
            end
            ST_EXEC1: begin
                if (opcode == OP_LOAD) begin
                    s.ram_rd = 1'b1;
                end else if (opcode == OP_STORE) begin
                    s.gpr_out    = 1'b1;
                    s.gpr_select = SEL_RD1;
                    s.mdr_in     = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    s.gpr_out     = 1'b1;
                    s.gpr_select  = SEL_RS1;
                    s.alu_control = alu_code(opcode);
                    s.z_in        = 1'b1;
                end else if (opcode == OP_MOV) begin
                    s.z_out      = 1'b1;
                    s.gpr_in     = 1'b1;
                    s.gpr_select = SEL_RD1;
                end
            end
            ST_EXEC2: begin
                if (opcode == OP_STORE) begin
                    s.ram_wr = 1'b1;
                end else if (is_alu_op(opcode)) begin
                    s.z_out      = 1'b1;
                    s.gpr_in     = 1'b1;
                    s.gpr_select = SEL_RD1;
                end
            end
            ST_EXEC3: begin
                if (opcode == OP_LOAD) begin
                    s.mdr_out    = 1'b1;
                    s.gpr_in     = 1'b1;
                    s.gpr_select = SEL_RD1;
                end
            end
            ST_HALT:  s.halted = 1'b1;
            default:  ;
        endcase
    end

    assign strobes = s;

endmodule

// File: rtl/fpg8_control_unit.sv
// FPG8 micro-sequencer: state register, next-state logic, sticky illegal-opcode
// flag, and run/reset gating of the decoded datapath strobes.
module fpg8_control_unit
    import fpg8_ctrl_pkg::*;
#(
    parameter logic [2:0] PC_SEL = SEL_PC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [2:0] ALU_control,
    output logic       GPR_in,
    output logic       GPR_out,
    output logic [2:0] GPR_select,
    output logic       IR_in,
    output logic       MAR_in,
    output logic       MDR_in,
    output logic       MDR_out,
    output logic       RAM_enable_read,
    output logic       RAM_enable_write,
    output logic       Y_in,
    output logic       Z_in,
    output logic       Z_out,
    output logic       halted,
    output logic       illegal_op,
    output logic [3:0] state_out
);

    state_t              state_q, state_d;
    logic                illegal_q, illegal_d;
    logic [STROBES_W-1:0] raw_strobes;
    strobes_t            gated;

    fpg8_ctrl_decode #(.PC_SEL(PC_SEL)) u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .strobes (raw_strobes)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        if (run) begin
            case (state_q)
                ST_FETCH0: state_d = ST_FETCH1;
                ST_FETCH1: state_d = ST_FETCH2;
                ST_FETCH2: state_d = ST_FETCH3;
                ST_FETCH3: state_d = ST_DECODE;
                ST_DECODE: begin
                    if (opcode == OP_HALT) begin
                        state_d = ST_HALT;
                    end else if ((opcode == OP_NOP) || is_illegal(opcode)) begin
                        state_d   = ST_FETCH0;
                        illegal_d = illegal_q | is_illegal(opcode);
                    end else begin
                        state_d = ST_EXEC0;
                    end
                end
                ST_EXEC0, ST_EXEC1, ST_EXEC2, ST_EXEC3: begin
                    // EXEC3 is the deepest step, so it always returns to fetch.
                    if ((state_q == last_exec(opcode)) || (state_q == ST_EXEC3))
                        state_d = ST_FETCH0;
                    else
                        state_d = state_t'(state_q + 4'd1);
                end
                ST_HALT:   state_d = ST_HALT;
                default:   state_d = ST_FETCH0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign gated = (run && !reset) ? strobes_t'(raw_strobes) : '0;

    assign ALU_control      = gated.alu_control;
    assign GPR_in           = gated.gpr_in;
    assign GPR_out          = gated.gpr_out;
    assign GPR_select       = gated.gpr_select;
    assign IR_in            = gated.ir_in;
    assign MAR_in           = gated.mar_in;
    assign MDR_in           = gated.mdr_in;
    assign MDR_out          = gated.mdr_out;
    assign RAM_enable_read  = gated.ram_rd;
    assign RAM_enable_write = gated.ram_wr;
    assign Y_in             = gated.y_in;
    assign Z_in             = gated.z_in;
    assign Z_out            = gated.z_out;
    assign halted           = gated.halted;
    assign illegal_op       = illegal_q;
    assign state_out        = state_q;

endmodule

// File: tb/tb_fpg8_control_unit.sv
// Directed bench for fpg8_control_unit: an instruction-step model checked every
// cycle, plus literal expectations at the interesting micro-steps.
module tb_fpg8_control_unit;

    logic       clk;
    logic       reset;
    logic       run;
    logic [3:0] opcode;
    logic [2:0] ALU_control;
    logic       GPR_in, GPR_out;
    logic [2:0] GPR_select;
    logic       IR_in, MAR_in, MDR_in, MDR_out;
    logic       RAM_enable_read, RAM_enable_write;
    logic       Y_in, Z_in, Z_out;
    logic       halted, illegal_op;
    logic [3:0] state_out;

    int total = 0;
    int bad   = 0;
    bit checking = 0;

    // Model: position within the current instruction (0-3 fetch, 4 decode, 5+ execute).
    int m_step = 0;
    bit m_halt = 0;
    bit m_ill  = 0;

    logic [2:0] e_alu, e_sel;
    logic e_gin, e_gout, e_ir, e_mar, e_mdrin, e_mdrout, e_rd, e_wr;
    logic e_y, e_zin, e_zout, e_halt;

    fpg8_control_unit dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .opcode           (opcode),
        .ALU_control      (ALU_control),
        .GPR_in           (GPR_in),
        .GPR_out          (GPR_out),
        .GPR_select       (GPR_select),
        .IR_in            (IR_in),
        .MAR_in           (MAR_in),
        .MDR_in           (MDR_in),
        .MDR_out          (MDR_out),
        .RAM_enable_read  (RAM_enable_read),
        .RAM_enable_write (RAM_enable_write),
        .Y_in             (Y_in),
        .Z_in             (Z_in),
        .Z_out            (Z_out),
        .halted           (halted),
        .illegal_op       (illegal_op),
        .state_out        (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int instrCycles(input logic [3:0] op);
        case (op)
            4'd1:                   return 9;
            4'd2, 4'd3, 4'd4, 4'd5,
            4'd6:                   return 8;
            4'd7:                   return 7;
            default:                return 5;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_step <= 0;
            m_halt <= 1'b0;
            m_ill  <= 1'b0;
        end else if (run && !m_halt) begin
            if (m_step == 4) begin
                if (opcode == 4'd15) begin
                    m_halt <= 1'b1;
                end else if (opcode == 4'd0 || opcode >= 4'd8) begin
                    m_ill  <= m_ill | (opcode >= 4'd8);
                    m_step <= 0;
                end else begin
                    m_step <= 5;
                end
            end else if (m_step + 1 == instrCycles(opcode)) begin
                m_step <= 0;
            end else begin
                m_step <= m_step + 1;
            end
        end
    end

    task modelOutputs();
        int k;
        {e_alu, e_sel} = '0;
        {e_gin, e_gout, e_ir, e_mar, e_mdrin, e_mdrout, e_rd, e_wr, e_y, e_zin, e_zout, e_halt} = '0;
        k = m_step - 5;
        if (run && !reset) begin
            if (m_halt) begin
                e_halt = 1'b1;
            end else if (m_step == 0) begin
                e_gout = 1; e_sel = 3'd4; e_mar = 1; e_alu = 3'd4; e_zin = 1;
            end else if (m_step == 1) begin
                e_rd = 1;
            end else if (m_step == 2) begin
                e_zout = 1; e_gin = 1; e_sel = 3'd4;
            end else if (m_step == 3) begin
                e_mdrout = 1; e_ir = 1;
            end else if (m_step >= 5) begin
                case (opcode)
                    4'd1: case (k)
                        0: begin e_gout = 1; e_sel = 3'd2; e_mar = 1; end
                        1: e_rd = 1;
                        3: begin e_mdrout = 1; e_gin = 1; e_sel = 3'd0; end
                        default: ;
                    endcase
                    4'd2: case (k)
                        0: begin e_gout = 1; e_sel = 3'd2; e_mar = 1; end
                        1: begin e_gout = 1; e_sel = 3'd0; e_mdrin = 1; end
                        2: e_wr = 1;
                        default: ;
                    endcase
                    4'd3, 4'd4, 4'd5, 4'd6: case (k)
                        0: begin e_gout = 1; e_sel = 3'd0; e_y = 1; end
                        1: begin e_gout = 1; e_sel = 3'd2; e_alu = 3'(opcode - 4'd3); e_zin = 1; end
                        2: begin e_zout = 1; e_gin = 1; e_sel = 3'd0; end
                        default: ;
                    endcase
                    4'd7: case (k)
                        0: begin e_gout = 1; e_sel = 3'd2; e_alu = 3'd5; e_zin = 1; end
                        1: begin e_zout = 1; e_gin = 1; e_sel = 3'd0; end
                        default: ;
                    endcase
                    default: ;
                endcase
            end
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            modelOutputs();
            checkOutput("state",   state_out, m_halt ? 4'd9 : 4'(m_step));
            checkOutput("illegal", {3'b000, illegal_op}, {3'b000, m_ill});
            checkOutput("alu",     {1'b0, ALU_control}, {1'b0, e_alu});
            checkOutput("sel",     {1'b0, GPR_select}, {1'b0, e_sel});
            checkOutput("gpr_in",  {3'b000, GPR_in}, {3'b000, e_gin});
            checkOutput("gpr_out", {3'b000, GPR_out}, {3'b000, e_gout});
            checkOutput("ir_in",   {3'b000, IR_in}, {3'b000, e_ir});
            checkOutput("mar_in",  {3'b000, MAR_in}, {3'b000, e_mar});
            checkOutput("mdr_in",  {3'b000, MDR_in}, {3'b000, e_mdrin});
            checkOutput("mdr_out", {3'b000, MDR_out}, {3'b000, e_mdrout});
            checkOutput("ram_rd",  {3'b000, RAM_enable_read}, {3'b000, e_rd});
            checkOutput("ram_wr",  {3'b000, RAM_enable_write}, {3'b000, e_wr});
            checkOutput("y_in",    {3'b000, Y_in}, {3'b000, e_y});
            checkOutput("z_in",    {3'b000, Z_in}, {3'b000, e_zin});
            checkOutput("z_out",   {3'b000, Z_out}, {3'b000, e_zout});
            checkOutput("halted",  {3'b000, halted}, {3'b000, e_halt});
            checkOutput("one_bus_driver", 4'(GPR_out + MDR_out + Z_out) <= 4'd1 ? 4'd1 : 4'd0, 4'd1);
            checkOutput("rd_wr_excl", {3'b000, RAM_enable_read & RAM_enable_write}, 4'd0);
        end
    end

    // Inputs change 1 time unit after a falling edge, away from both sampling points.
    task automatic applyStimulus(input logic r, input logic rn, input logic [3:0] op);
        #1;
        reset  = r;
        run    = rn;
        opcode = op;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; opcode = 4'd0;
        waitCycles(2);
        #1 checking = 1'b1;
        checkOutput("lit_reset_state", state_out, 4'd0);
        checkOutput("lit_reset_illegal", {3'b000, illegal_op}, 4'd0);

        applyStimulus(1, 1, 4'd0);
        #1;
        checkOutput("lit_reset_gpr_out", {3'b000, GPR_out}, 4'd0);
        checkOutput("lit_reset_alu", {1'b0, ALU_control}, 4'd0);
        waitCycles(1);

        // NOP: FETCH0..3, DECODE, back to FETCH0
        applyStimulus(0, 1, 4'd0);
        #1;
        checkOutput("lit_f0_gpr_out", {3'b000, GPR_out}, 4'd1);
        checkOutput("lit_f0_sel", {1'b0, GPR_select}, 4'd4);
        checkOutput("lit_f0_mar", {3'b000, MAR_in}, 4'd1);
        checkOutput("lit_f0_alu", {1'b0, ALU_control}, 4'd4);
        checkOutput("lit_f0_zin", {3'b000, Z_in}, 4'd1);
        for (int i = 1; i <= 5; i++) begin
            waitCycles(1);
            checkOutput("lit_nop_state", state_out, (i == 5) ? 4'd0 : 4'(i));
        end

        // ADD
        applyStimulus(0, 1, 4'd3);
        waitCycles(5);
        checkOutput("lit_add_e0_y", {3'b000, Y_in}, 4'd1);
        checkOutput("lit_add_e0_sel", {1'b0, GPR_select}, 4'd0);
        waitCycles(1);
        checkOutput("lit_add_e1_alu", {1'b0, ALU_control}, 4'd0);
        checkOutput("lit_add_e1_sel", {1'b0, GPR_select}, 4'd2);
        waitCycles(1);
        checkOutput("lit_add_e2_zout", {3'b000, Z_out}, 4'd1);
        checkOutput("lit_add_e2_gin", {3'b000, GPR_in}, 4'd1);
        waitCycles(1);
        checkOutput("lit_add_done", state_out, 4'd0);

        // SUB and OR reach distinct ALU codes
        applyStimulus(0, 1, 4'd4);
        waitCycles(6);
        checkOutput("lit_sub_alu", {1'b0, ALU_control}, 4'd1);
        waitCycles(2);
        applyStimulus(0, 1, 4'd6);
        waitCycles(6);
        checkOutput("lit_or_alu", {1'b0, ALU_control}, 4'd3);
        waitCycles(2);

        // LOAD: 9 cycles
        applyStimulus(0, 1, 4'd1);
        waitCycles(1);
        checkOutput("lit_load_f1_rd", {3'b000, RAM_enable_read}, 4'd1);
        waitCycles(5);
        checkOutput("lit_load_e1_rd", {3'b000, RAM_enable_read}, 4'd1);
        waitCycles(2);
        checkOutput("lit_load_e3_mdr_out", {3'b000, MDR_out}, 4'd1);
        checkOutput("lit_load_e3_sel", {1'b0, GPR_select}, 4'd0);
        waitCycles(1);
        checkOutput("lit_load_done", state_out, 4'd0);

        // MOV: 7 cycles
        applyStimulus(0, 1, 4'd7);
        waitCycles(5);
        checkOutput("lit_mov_alu", {1'b0, ALU_control}, 4'd5);
        waitCycles(2);
        checkOutput("lit_mov_done", state_out, 4'd0);

        // Illegal opcode sets a sticky flag
        applyStimulus(0, 1, 4'd9);
        waitCycles(4);
        checkOutput("lit_ill_before", {3'b000, illegal_op}, 4'd0);
        waitCycles(1);
        checkOutput("lit_ill_after", {3'b000, illegal_op}, 4'd1);
        checkOutput("lit_ill_state", state_out, 4'd0);
        applyStimulus(0, 1, 4'd0);
        waitCycles(5);
        checkOutput("lit_ill_sticky", {3'b000, illegal_op}, 4'd1);

        // HALT holds until reset
        applyStimulus(0, 1, 4'd15);
        waitCycles(5);
        checkOutput("lit_halt", {3'b000, halted}, 4'd1);
        waitCycles(20);
        checkOutput("lit_halt_state", state_out, 4'd9);
        applyStimulus(1, 1, 4'd15);
        #1;
        checkOutput("lit_halt_reset_gate", {3'b000, halted}, 4'd0);
        waitCycles(1);
        checkOutput("lit_halt_reset_state", state_out, 4'd0);
        checkOutput("lit_halt_reset_ill", {3'b000, illegal_op}, 4'd0);

        // STORE paused in E1
        applyStimulus(0, 1, 4'd2);
        waitCycles(6);
        checkOutput("lit_st_e1_state", state_out, 4'd6);
        applyStimulus(0, 0, 4'd2);
        #1;
        checkOutput("lit_st_pause_mdr_in", {3'b000, MDR_in}, 4'd0);
        waitCycles(3);
        checkOutput("lit_st_pause_state", state_out, 4'd6);
        applyStimulus(0, 1, 4'd2);
        #1;
        checkOutput("lit_st_resume_mdr_in", {3'b000, MDR_in}, 4'd1);
        waitCycles(1);
        checkOutput("lit_st_e2_wr", {3'b000, RAM_enable_write}, 4'd1);
        checkOutput("lit_st_e2_mdr_in", {3'b000, MDR_in}, 4'd0);
        waitCycles(1);
        checkOutput("lit_st_done", state_out, 4'd0);

        // Reset in the middle of an ALU instruction
        applyStimulus(0, 1, 4'd5);
        waitCycles(6);
        applyStimulus(1, 1, 4'd5);
        waitCycles(1);
        checkOutput("lit_mid_reset", state_out, 4'd0);
        applyStimulus(0, 1, 4'd0);
        waitCycles(5);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
